// File: rtl/orb_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : orb_dispatch_arbiter
//  Purpose  : Round-robin dispatch of detected corners to descriptor workers,
//             round-robin collection of worker results into an output FIFO,
//             drop counting and upstream stall request generation.
//  Revision : 1.0 - initial release
// ============================================================================
module orb_dispatch_arbiter #(
  parameter int NUM_WORKERS     = 16,
  parameter int DESC_BITS       = 256,
  parameter int COORD_BITS      = 10,
  parameter int FIFO_ADDR_BITS  = 3,
  parameter int STALL_MODE      = 0,
  parameter int STALL_THRESHOLD = 2
) (
  input  logic                              clk,
  input  logic                              in_reset,
  input  logic                              in_valid,
  input  logic                              in_is_corner,
  input  logic [COORD_BITS-1:0]             in_x,
  input  logic [COORD_BITS-1:0]             in_y,
  input  logic [NUM_WORKERS-1:0]            in_mask,
  input  logic [NUM_WORKERS-1:0]            worker_ready,
  input  logic [NUM_WORKERS-1:0]            worker_accepting,
  output logic [NUM_WORKERS-1:0]            worker_go,
  input  logic [NUM_WORKERS-1:0]            worker_valid,
  input  logic [NUM_WORKERS*DESC_BITS-1:0]  worker_desc,
  input  logic [NUM_WORKERS*COORD_BITS-1:0] worker_x,
  input  logic [NUM_WORKERS*COORD_BITS-1:0] worker_y,
  output logic [NUM_WORKERS-1:0]            worker_ack,
  input  logic                              in_consume,
  output logic                              out_valid,
  output logic [DESC_BITS-1:0]              out_descriptor,
  output logic [COORD_BITS-1:0]             out_feature_x,
  output logic [COORD_BITS-1:0]             out_feature_y,
  output logic [FIFO_ADDR_BITS:0]           out_fifo_level,
  output logic [15:0]                       out_dropped,
  output logic                              out_request_stall
);

  localparam int PTR_W   = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam int DEPTH   = 1 << FIFO_ADDR_BITS;
  localparam int ENTRY_W = DESC_BITS + 2 * COORD_BITS;
  localparam logic [PTR_W-1:0]        LAST_IDX  = PTR_W'(NUM_WORKERS - 1);
  localparam logic [FIFO_ADDR_BITS:0] FULL_LVL  = (FIFO_ADDR_BITS + 1)'(DEPTH);

  // First set bit of vec at or above start (with wrap); MSB of result = found.
  // Scanning offsets downward lets the smallest offset win the last write.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_WORKERS-1:0] vec,
                                             input logic [PTR_W-1:0] start);
    logic [PTR_W:0] res;
    int pos;
    res = '0;
    for (int off = NUM_WORKERS - 1; off >= 0; off--) begin
      pos = int'(start) + off;
      if (pos >= NUM_WORKERS) pos = pos - NUM_WORKERS;
      if (vec[pos[PTR_W-1:0]]) res = {1'b1, pos[PTR_W-1:0]};
    end
    return res;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  logic [PTR_W-1:0]          dp, cp;
  logic [NUM_WORKERS-1:0]    eligible, unmasked;
  logic [PTR_W:0]            go_pick, col_pick;
  logic                      corner_now, dispatch, drop, push, pop, fifo_full;
  logic [ENTRY_W-1:0]        sel_entry, head_entry;
  logic [ENTRY_W-1:0]        mem [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [5:0]                elig_cnt;

  // Coordinates of the incoming pixel travel with the worker result instead.
  logic unused_inputs;
  assign unused_inputs = ^{in_x, in_y};

  assign eligible   = worker_ready & ~in_mask;
  assign unmasked   = ~in_mask;
  assign go_pick    = rr_pick(eligible, dp);
  assign col_pick   = rr_pick(worker_valid, cp);
  assign corner_now = in_valid & in_is_corner & ~in_reset;
  assign dispatch   = corner_now & go_pick[PTR_W];
  assign drop       = corner_now & ~go_pick[PTR_W];
  assign fifo_full  = (out_fifo_level == FULL_LVL);
  assign pop        = in_consume & out_valid & ~in_reset;
  assign push       = col_pick[PTR_W] & ~in_reset & (~fifo_full | pop);

  assign worker_go  = dispatch ? (NUM_WORKERS'(1) << go_pick[PTR_W-1:0]) : '0;
  assign worker_ack = push ? (NUM_WORKERS'(1) << col_pick[PTR_W-1:0]) : '0;

  // Select the granted worker's descriptor and coordinates for the FIFO write.
  always_comb begin
    sel_entry = '0;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      if (col_pick[PTR_W-1:0] == PTR_W'(i))
        sel_entry = {worker_desc[i*DESC_BITS +: DESC_BITS],
                     worker_x[i*COORD_BITS +: COORD_BITS],
                     worker_y[i*COORD_BITS +: COORD_BITS]};
    end
  end

  // Count eligible workers and derive the stall request for the chosen policy.
  always_comb begin
    elig_cnt = '0;
    for (int i = 0; i < NUM_WORKERS; i++) elig_cnt = elig_cnt + 6'(eligible[i]);
    if (unmasked == '0)
      out_request_stall = 1'b1;
    else if (STALL_MODE == 0)
      out_request_stall = ~|(worker_accepting & unmasked);
    else if (STALL_MODE == 1)
      out_request_stall = |(unmasked & ~worker_accepting);
    else
      out_request_stall = (int'(elig_cnt) < STALL_THRESHOLD);
  end

  // Round-robin pointers, drop counter and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (in_reset) begin
      dp             <= '0;
      cp             <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      out_fifo_level <= '0;
      out_dropped    <= '0;
    end else begin
      if (dispatch) dp <= ptr_next(go_pick[PTR_W-1:0]);
      if (push)     cp <= ptr_next(col_pick[PTR_W-1:0]);
      if (drop && out_dropped != 16'hFFFF) out_dropped <= out_dropped + 16'd1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   out_fifo_level <= out_fifo_level + 1'b1;
        2'b01:   out_fifo_level <= out_fifo_level - 1'b1;
        default: out_fifo_level <= out_fifo_level;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sel_entry;
  end

  assign head_entry     = mem[rd_ptr];
  assign out_valid      = (out_fifo_level != '0);
  assign out_descriptor = head_entry[ENTRY_W-1 -: DESC_BITS];
  assign out_feature_x  = head_entry[2*COORD_BITS-1 -: COORD_BITS];
  assign out_feature_y  = head_entry[COORD_BITS-1:0];

endmodule
`default_nettype wire

// File: tb/tb_orb_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_orb_dispatch_arbiter
//  Purpose  : Directed self-checking bench for orb_dispatch_arbiter
//             (4 workers, 16-bit descriptors, 8-entry FIFO).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_orb_dispatch_arbiter;

  localparam int NW = 4;
  localparam int DB = 16;
  localparam int CB = 10;
  localparam int FA = 3;

  logic          clk = 1'b0;
  logic          in_reset, in_valid, in_is_corner, in_consume;
  logic [CB-1:0] in_x, in_y;
  logic [NW-1:0] in_mask, worker_ready, worker_accepting, worker_valid;
  logic [NW-1:0] worker_go, worker_ack;
  logic [DB-1:0] desc_a [NW];
  logic [CB-1:0] x_a [NW];
  logic [CB-1:0] y_a [NW];
  logic [NW*DB-1:0] worker_desc;
  logic [NW*CB-1:0] worker_x, worker_y;
  logic          out_valid, out_request_stall;
  logic [DB-1:0] out_descriptor;
  logic [CB-1:0] out_feature_x, out_feature_y;
  logic [FA:0]   out_fifo_level;
  logic [15:0]   out_dropped;

  // Outputs of the mode-0 and mode-1 stall instances
  logic [NW-1:0] m0_go, m0_ack, m1_go, m1_ack;
  logic          m0_valid, m1_valid, m0_stall, m1_stall;
  logic [DB-1:0] m0_desc, m1_desc;
  logic [CB-1:0] m0_x, m0_y, m1_x, m1_y;
  logic [FA:0]   m0_lvl, m1_lvl;
  logic [15:0]   m0_drop, m1_drop;

  int vectors = 0;
  int miscompares = 0;

  assign worker_desc = {desc_a[3], desc_a[2], desc_a[1], desc_a[0]};
  assign worker_x    = {x_a[3], x_a[2], x_a[1], x_a[0]};
  assign worker_y    = {y_a[3], y_a[2], y_a[1], y_a[0]};

  always #5 clk = ~clk;

  orb_dispatch_arbiter #(.NUM_WORKERS(NW), .DESC_BITS(DB), .COORD_BITS(CB),
    .FIFO_ADDR_BITS(FA), .STALL_MODE(2), .STALL_THRESHOLD(2)) dut (
    .clk(clk), .in_reset(in_reset), .in_valid(in_valid), .in_is_corner(in_is_corner),
    .in_x(in_x), .in_y(in_y), .in_mask(in_mask), .worker_ready(worker_ready),
    .worker_accepting(worker_accepting), .worker_go(worker_go), .worker_valid(worker_valid),
    .worker_desc(worker_desc), .worker_x(worker_x), .worker_y(worker_y),
    .worker_ack(worker_ack), .in_consume(in_consume), .out_valid(out_valid),
    .out_descriptor(out_descriptor), .out_feature_x(out_feature_x),
    .out_feature_y(out_feature_y), .out_fifo_level(out_fifo_level),
    .out_dropped(out_dropped), .out_request_stall(out_request_stall));

  orb_dispatch_arbiter #(.NUM_WORKERS(NW), .DESC_BITS(DB), .COORD_BITS(CB),
    .FIFO_ADDR_BITS(FA), .STALL_MODE(0), .STALL_THRESHOLD(2)) u_mode0 (
    .clk(clk), .in_reset(in_reset), .in_valid(in_valid), .in_is_corner(in_is_corner),
    .in_x(in_x), .in_y(in_y), .in_mask(in_mask), .worker_ready(worker_ready),
    .worker_accepting(worker_accepting), .worker_go(m0_go), .worker_valid(worker_valid),
    .worker_desc(worker_desc), .worker_x(worker_x), .worker_y(worker_y),
    .worker_ack(m0_ack), .in_consume(in_consume), .out_valid(m0_valid),
    .out_descriptor(m0_desc), .out_feature_x(m0_x), .out_feature_y(m0_y),
    .out_fifo_level(m0_lvl), .out_dropped(m0_drop), .out_request_stall(m0_stall));

  orb_dispatch_arbiter #(.NUM_WORKERS(NW), .DESC_BITS(DB), .COORD_BITS(CB),
    .FIFO_ADDR_BITS(FA), .STALL_MODE(1), .STALL_THRESHOLD(2)) u_mode1 (
    .clk(clk), .in_reset(in_reset), .in_valid(in_valid), .in_is_corner(in_is_corner),
    .in_x(in_x), .in_y(in_y), .in_mask(in_mask), .worker_ready(worker_ready),
    .worker_accepting(worker_accepting), .worker_go(m1_go), .worker_valid(worker_valid),
    .worker_desc(worker_desc), .worker_x(worker_x), .worker_y(worker_y),
    .worker_ack(m1_ack), .in_consume(in_consume), .out_valid(m1_valid),
    .out_descriptor(m1_desc), .out_feature_x(m1_x), .out_feature_y(m1_y),
    .out_fifo_level(m1_lvl), .out_dropped(m1_drop), .out_request_stall(m1_stall));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    tick();
    in_reset = 1'b0;
  endtask

  initial begin
    in_reset = 1'b1; in_valid = 1'b0; in_is_corner = 1'b0; in_consume = 1'b0;
    in_x = '0; in_y = '0; in_mask = '0; worker_ready = '0;
    worker_accepting = '0; worker_valid = '0;
    for (int i = 0; i < NW; i++) begin
      desc_a[i] = DB'(16'hD000 + i); x_a[i] = CB'(i); y_a[i] = CB'(i + 8);
    end
    tick(); tick();

    // Strobes stay low while reset is held, even with requests present
    in_valid = 1'b1; in_is_corner = 1'b1; worker_ready = 4'hF; worker_valid = 4'hF;
    #1;
    check("go_in_reset", 32'(worker_go), 32'h0);
    check("ack_in_reset", 32'(worker_ack), 32'h0);
    tick();
    in_reset = 1'b0; in_valid = 1'b0; worker_valid = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_level", 32'(out_fifo_level), 32'h0);
    check("rst_dropped", 32'(out_dropped), 32'h0);

    // Round-robin dispatch over all four workers, then wrap
    worker_ready = 4'hF; in_valid = 1'b1; in_is_corner = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr_go_%0d", k), 32'(worker_go), 32'(4'b0001 << (k % 4)));
      tick();
    end
    in_valid = 1'b0;

    // Masked workers skipped; dp lands past the chosen worker
    do_reset();
    in_mask = 4'b0011; in_valid = 1'b1;
    #1;
    check("mask_go", 32'(worker_go), 32'h4);
    tick();
    in_mask = 4'b0000;
    #1;
    check("mask_dp_next", 32'(worker_go), 32'h8);
    tick();
    in_valid = 1'b0;

    // Drop counting, reset clearing and saturation
    do_reset();
    worker_ready = 4'h0; in_valid = 1'b1;
    #1;
    check("drop_go_zero", 32'(worker_go), 32'h0);
    tick(); tick(); tick();
    in_valid = 1'b0;
    #1;
    check("drop_3", 32'(out_dropped), 32'd3);
    do_reset();
    check("drop_reset", 32'(out_dropped), 32'd0);
    in_valid = 1'b1; in_is_corner = 1'b0;
    tick();
    check("noncorner_no_drop", 32'(out_dropped), 32'd0);
    in_is_corner = 1'b1;
    tick();
    in_valid = 1'b0;
    check("drop_1", 32'(out_dropped), 32'd1);
    in_valid = 1'b1;
    repeat (65533) tick();
    check("drop_fffe", 32'(out_dropped), 32'hFFFE);
    tick(); tick();
    check("drop_sat", 32'(out_dropped), 32'hFFFF);
    tick();
    check("drop_sat_hold", 32'(out_dropped), 32'hFFFF);
    in_valid = 1'b0;

    // Fill the FIFO, hold the ninth result, then accept it on a pop
    do_reset();
    worker_valid = 4'b0001;
    for (int n = 0; n < 8; n++) begin
      desc_a[0] = DB'(16'h100 + n);
      #1;
      check($sformatf("fill_level_%0d", n), 32'(out_fifo_level), 32'(n));
      check($sformatf("fill_ack_%0d", n), 32'(worker_ack), 32'h1);
      tick();
    end
    check("full_level", 32'(out_fifo_level), 32'd8);
    desc_a[0] = 16'h108;
    #1;
    check("full_ack_held", 32'(worker_ack), 32'h0);
    tick();
    check("full_level_hold", 32'(out_fifo_level), 32'd8);
    in_consume = 1'b1;
    #1;
    check("full_pop_ack", 32'(worker_ack), 32'h1);
    check("full_head", 32'(out_descriptor), 32'h100);
    tick();
    in_consume = 1'b0; worker_valid = '0;
    #1;
    check("full_swap_level", 32'(out_fifo_level), 32'd8);
    for (int n = 1; n <= 8; n++) begin
      in_consume = 1'b1;
      #1;
      check($sformatf("drain_%0d", n), 32'(out_descriptor), 32'(16'h100 + n));
      tick();
    end
    in_consume = 1'b0;
    #1;
    check("drained_valid", 32'(out_valid), 32'h0);
    in_consume = 1'b1;
    tick();
    in_consume = 1'b0;
    check("empty_pop_ignored", 32'(out_fifo_level), 32'h0);

    // Collection order from cp=2 with workers 1 and 3 pending
    do_reset();
    desc_a[1] = 16'h111; x_a[1] = 10'd11; y_a[1] = 10'd21;
    worker_valid = 4'b0010;
    #1;
    check("cp_prime_ack", 32'(worker_ack), 32'h2);
    tick();
    worker_valid = '0; in_consume = 1'b1;
    tick();
    in_consume = 1'b0;
    desc_a[3] = 16'h333; x_a[3] = 10'd13; y_a[3] = 10'd23;
    worker_valid = 4'b1010;
    #1;
    check("col_ack_3", 32'(worker_ack), 32'h8);
    check("col_empty_before", 32'(out_valid), 32'h0);
    tick();
    check("col_valid_lat", 32'(out_valid), 32'h1);
    worker_valid = 4'b0010;
    #1;
    check("col_ack_1", 32'(worker_ack), 32'h2);
    tick();
    worker_valid = '0;
    check("col_level", 32'(out_fifo_level), 32'd2);
    in_consume = 1'b1;
    #1;
    check("col_head_3", 32'(out_descriptor), 32'h333);
    check("col_x_3", 32'(out_feature_x), 32'd13);
    tick();
    check("col_head_1", 32'(out_descriptor), 32'h111);
    check("col_y_1", 32'(out_feature_y), 32'd21);
    tick();
    in_consume = 1'b0;

    // Same worker dispatched and collected in one cycle
    worker_ready = 4'b0100; worker_valid = 4'b0100; in_valid = 1'b1;
    #1;
    check("same_go", 32'(worker_go), 32'h4);
    check("same_ack", 32'(worker_ack), 32'h4);
    tick();
    in_valid = 1'b0; worker_valid = '0;

    // Stall policies
    in_mask = 4'h0; worker_ready = 4'b0010; worker_accepting = 4'hF;
    #1;
    check("stall2_one", 32'(out_request_stall), 32'h1);
    worker_ready = 4'b0011;
    #1;
    check("stall2_two", 32'(out_request_stall), 32'h0);
    in_mask = 4'hF; worker_ready = 4'hF;
    #1;
    check("stall2_allmask", 32'(out_request_stall), 32'h1);
    check("stall0_allmask", 32'(m0_stall), 32'h1);
    check("stall1_allmask", 32'(m1_stall), 32'h1);
    in_mask = 4'h0; worker_accepting = 4'b0001;
    #1;
    check("stall0_one_acc", 32'(m0_stall), 32'h0);
    worker_accepting = 4'b0000;
    #1;
    check("stall0_none_acc", 32'(m0_stall), 32'h1);
    worker_accepting = 4'b0111;
    #1;
    check("stall1_one_busy", 32'(m1_stall), 32'h1);
    in_mask = 4'b1000;
    #1;
    check("stall1_busy_masked", 32'(m1_stall), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
